// File: rtl/ram_memory_loader.sv
// ram_memory_loader
// Byte-addressed RAM shared by a word loader and a datapath port.
// The loader serialises each accepted word into bytes at an auto-incrementing
// pointer, writing the MSB first. The datapath port does 1-cycle registered word
// reads (big-endian assembly) and byte-enabled writes. The datapath can only write
// while the loader is disabled and idle.

module ram_memory_loader #(
    parameter int NB_DATA    = 32,
    parameter int NB_BYTE    = 8,
    parameter int NB_ADDRESS = 8,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_load_enable,
    input  logic                                i_load_valid,
    input  logic [NB_DATA-1:0]                  i_load_data,
    input  logic                                i_clear_pointer,
    output logic                                o_load_ready,
    output logic                                o_load_full,
    output logic [NB_ADDRESS-1:0]               o_load_pointer,
    input  logic [NB_ADDRESS-1:0]               i_address,
    input  logic [NB_DATA-1:0]                  i_write_data,
    input  logic                                i_write_enable,
    input  logic [(NB_DATA/NB_BYTE)-1:0]        i_byte_enable,
    output logic [NB_DATA-1:0]                  o_read_data
);

    localparam int NB_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT        = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;
    localparam int NB_IDX        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Reduce a byte address into the physical RAM range.
    function automatic logic [NB_ADDRESS-1:0] mod_depth(input logic [NB_ADDRESS-1:0] a);
        return NB_ADDRESS'(32'(a) % 32'(RAM_DEPTH));
    endfunction

    // Narrow an in-range byte address to the array index width.
    function automatic logic [NB_IDX-1:0] ram_idx(input logic [NB_ADDRESS-1:0] a);
        return NB_IDX'(a);
    endfunction

    logic [NB_BYTE-1:0]    r_ram [0:RAM_DEPTH-1];
    state_t                r_state;
    state_t                w_next_state;
    logic [NB_ADDRESS-1:0] r_pointer;
    logic                  r_full;
    logic [NB_CNT-1:0]     r_byte_cnt;
    logic [NB_DATA-1:0]    r_word;
    logic [NB_DATA-1:0]    r_read_data;
    logic [NB_DATA-1:0]    w_read_word;
    logic [NB_ADDRESS-1:0] w_base;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_dp_write;
    logic                  w_clear_ok;

    // The low address bits select a byte within the word, so they are masked off.
    // An aligned address reduced modulo RAM_DEPTH stays aligned because RAM_DEPTH
    // is a multiple of the word size.
    assign w_base      = mod_depth(i_address & ~NB_ADDRESS'(NB_WORD_BYTES - 1));
    // The i_reset term keeps ready low while reset is asserted.
    assign w_ready     = (r_state == ST_IDLE) & i_load_enable & ~r_full & i_reset;
    assign w_accept    = w_ready & i_load_valid;
    assign w_last_byte = (r_byte_cnt == NB_CNT'(NB_WORD_BYTES - 1));
    // The datapath may write only when the loader is disabled and idle.
    assign w_dp_write  = i_write_enable & ~i_load_enable & (r_state == ST_IDLE) & i_reset;
    // A pointer clear is honoured only outside a word being written.
    assign w_clear_ok  = i_clear_pointer & (r_state != ST_WRITE);

    assign o_load_ready   = w_ready;
    assign o_load_full    = r_full;
    assign o_load_pointer = r_pointer;
    assign o_read_data    = r_read_data;

    // Loader state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Loader next-state logic: an accepted word takes NB_WORD_BYTES write cycles plus one DONE cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_last_byte) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Loader pointer, full flag, byte counter, word shifter, and registered read data.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pointer   <= '0;
            r_full      <= 1'b0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_read_data <= '0;
        end else begin
            r_read_data <= w_read_word;
            case (r_state)
                ST_WRITE: begin
                    r_word     <= r_word << NB_BYTE;
                    r_byte_cnt <= r_byte_cnt + NB_CNT'(1);
                    if (r_pointer == NB_ADDRESS'(RAM_DEPTH - 1)) begin
                        r_pointer <= '0;
                        r_full    <= 1'b1;
                    end else begin
                        r_pointer <= r_pointer + NB_ADDRESS'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (w_clear_ok) begin
                        r_pointer <= '0;
                        r_full    <= 1'b0;
                    end
                    if (w_accept) begin
                        r_word     <= i_load_data;
                        r_byte_cnt <= '0;
                    end
                end
                default: begin
                    r_byte_cnt <= '0;
                end
            endcase
        end
    end

    // RAM write port. Contents are deliberately not reset, so a partially loaded word keeps its written bytes.
    always_ff @(posedge i_clock) begin
        if (r_state == ST_WRITE) begin
            r_ram[ram_idx(r_pointer)] <= r_word[NB_DATA-1 -: NB_BYTE];
        end else if (w_dp_write) begin
            for (int k = 0; k < NB_WORD_BYTES; k++) begin
                if (i_byte_enable[k]) begin
                    r_ram[ram_idx(w_base + NB_ADDRESS'(NB_WORD_BYTES - 1 - k))] <= i_write_data[k*NB_BYTE +: NB_BYTE];
                end
            end
        end
    end

    // Big-endian word assembly: the lowest address lands in the most significant byte.
    always_comb begin
        w_read_word = '0;
        for (int k = 0; k < NB_WORD_BYTES; k++) begin
            w_read_word[NB_DATA-1-k*NB_BYTE -: NB_BYTE] = r_ram[ram_idx(w_base + NB_ADDRESS'(k))];
        end
    end

endmodule
